osd_spi_tx: RTL and testbench
=============================

# osd_spi_tx

SPI master that drives the OSD command channel (SPI_SCK / SPI_SS3 / SPI_DI of the OSD overlay) from inside the FPGA. It serialises OSD enable/disable commands and full 256-byte line-write transactions, fetching payload bytes from a synchronous byte RAM. It sits between a core-side menu/text renderer and the OSD overlay block, taking the place of the external IO controller.

## Interface
- CLK_DIV, 4: SCK half-period in clk_sys cycles; legal range 2..255.
- clk_sys  in  1  system clock; every output is registered on it.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a transfer happens when cmd_valid && cmd_ready.
- cmd_type  in  2  command: 0 = disable, 1 = enable, 2 = write line, 3 = reserved.
- cmd_line  in  3  OSD line (0..7) for a write.
- busy  out  1  high from command accept until return to IDLE.
- rd_en  out  1  one-cycle read strobe to the payload RAM.
- rd_addr  out  8  payload byte index 0..255.
- rd_data  in  8  payload byte; valid on the cycle after rd_en.
- SPI_SCK  out  1  serial clock; idles low.
- SPI_SS3  out  1  select, active low; idles high.
- SPI_DO  out  1  serial data, MSB first; connects to the OSD SPI_DI input.

## Operation
- Reset values: cmd_ready=1, busy=0, rd_en=0, rd_addr=0, SPI_SCK=0, SPI_SS3=1, SPI_DO=0. The state register resets to IDLE.
- Command byte on accept:
  - disable = 0x40
  - enable = 0x41
  - write = 0x20 | cmd_line
  - type 3 is accepted and dropped: no SPI activity and no busy.
- Frame for enable/disable: the command byte only.
- Frame for write: the command byte, then 256 payload bytes with rd_addr 0..255 in order.
- The frame is one SS3-low period. The receiver samples SPI_DO on the SCK rising edge.
- State machine:
  - IDLE: on accept, load the command byte into the shift register, assert SS3 low, drive the MSB onto SPI_DO, go to LO.
  - LO: SCK=0 for CLK_DIV cycles, then go to HI.
  - HI: SCK=1 for CLK_DIV cycles. At the end of HI, if bits remain in the byte, shift, drive the next bit and go to LO.
    - Else if payload bytes remain, load the prefetched byte, drive its MSB and go to LO.
    - Else go to HOLD.
  - HOLD: SCK=0, SS3 stays low for CLK_DIV cycles, then go to DESEL.
  - DESEL: SS3=1, SCK=0, DO=0 for 2*CLK_DIV cycles, then go to IDLE.
- SPI_DO changes only while SCK is low, and always at least CLK_DIV cycles before the rising edge.
- Payload prefetch: rd_en pulses with rd_addr=k on the first cycle of the HI phase of bit 0 of the preceding byte; for byte 0 the preceding byte is the command byte. rd_data is captured into a holding register on the following cycle.
- Bit counter is 3-bit and wraps 7→0 per byte. The byte counter is 9-bit and counts 0..256.
- cmd_valid is ignored while busy. cmd_type and cmd_line are sampled only on accept.

## Timing
- Accept at cycle 0; SS3 is low from cycle 1 with DO = bit 7.
- First SCK rise at cycle 1+CLK_DIV. Each bit occupies 2*CLK_DIV cycles.
- SS3 low duration:
  - enable/disable: 16*CLK_DIV + CLK_DIV
  - write: 2056*2*CLK_DIV + CLK_DIV
- cmd_ready returns 2*CLK_DIV cycles after SS3 rises. Back-to-back commands therefore see at least 2*CLK_DIV cycles of SS3 high between frames.
- busy is high from cycle 1 through the last DESEL cycle. cmd_ready is its complement, except that cmd_ready=1 during a dropped type-3 accept.
- Reset asserted mid-frame takes effect asynchronously: SS3=1 and SCK=0 immediately, the partial frame is abandoned, and no rd_en is issued after reset. The OSD receiver discards partial frames on SS3 high.

## Test plan
- Enable, CLK_DIV=4: a receiver model captures 0x41 with 8 SCK rises spaced 8 cycles apart. SS3 is low for 68 cycles and cmd_ready returns 8 cycles after SS3 rises.
- Write line 5 with RAM content = addr ^ 0x5A: the receiver captures 0x25, then bytes 0x5A, 0x5B, … 0xA5, 256 in total. rd_addr is monotonic 0..255, there are exactly 256 rd_en pulses, and there are 2056 SCK rises.
- Disable issued immediately after enable (cmd_valid held): two frames (0x41 then 0x40), SS3 high for at least 8 cycles between them, and no overlap.
- Reset asserted at payload byte 100 of a write: SS3=1 and SCK=0 in the same cycle. The outputs equal their reset values, cmd_ready=1 after reset releases, and a subsequent enable frame is clean.
- cmd_type=3 with cmd_valid: the bench observes no SS3 or SCK toggle, busy stays 0 and cmd_ready stays 1.
- CLK_DIV=2: the bench checks that SPI_DO is stable for at least 2 cycles before every SCK rise and throughout the high phase. The prefetch still meets the deadline and all 256 bytes arrive correctly.

Source files
------------

// File: rtl/osd_spi_tx.sv
// SPI master for the OSD command channel: sends enable/disable command bytes and
// 256-byte line writes, prefetching each payload byte from a synchronous byte RAM.
module osd_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [2:0] cmd_line,
  output logic       busy,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DO
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LO    = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DESEL = 3'd4;

  localparam logic [8:0] DIV_LAST   = 9'(CLK_DIV - 1);
  localparam logic [8:0] DESEL_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] LAST_BYTE  = 9'd256;

  logic [2:0] state_q, state_d;
  logic [8:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [8:0] byte_q, byte_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       cap_q, cap_d;
  logic       is_wr_q, is_wr_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       sck_q, sck_d;
  logic       ss_q, ss_d;
  logic       do_q, do_d;

  logic       accept;
  logic       div_end;
  logic       more_bytes;
  logic [7:0] next_byte;
  logic [7:0] cmd_byte;

  assign accept     = cmd_valid && ready_q;
  assign div_end    = (div_q == DIV_LAST);
  assign more_bytes = is_wr_q && (byte_q != LAST_BYTE);
  // With CLK_DIV=2 the RAM data lands on the same edge the byte is loaded,
  // so bypass the holding register in that cycle.
  assign next_byte  = cap_q ? rd_data : hold_q;

  always_comb begin
    cmd_byte = 8'h40;
    case (cmd_type)
      2'd0:    cmd_byte = 8'h40;
      2'd1:    cmd_byte = 8'h41;
      default: cmd_byte = {5'b00100, cmd_line};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    hold_d    = next_byte;
    cap_d     = rd_en_q;
    is_wr_d   = is_wr_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    sck_d     = sck_q;
    ss_d      = ss_q;
    do_d      = do_q;

    case (state_q)
      S_IDLE: begin
        // Type 3 is accepted (ready stays high) but produces no frame.
        if (accept && (cmd_type != 2'd3)) begin
          state_d = S_LO;
          div_d   = 9'd0;
          bit_d   = 3'd0;
          byte_d  = 9'd0;
          is_wr_d = (cmd_type == 2'd2);
          shift_d = cmd_byte;
          do_d    = cmd_byte[7];
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end

      S_LO: begin
        if (div_end) begin
          state_d = S_HI;
          div_d   = 9'd0;
          sck_d   = 1'b1;
          // Fetch the next payload byte while the last bit of this one is high.
          if ((bit_q == 3'd7) && more_bytes) begin
            rd_en_d   = 1'b1;
            rd_addr_d = byte_q[7:0];
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end

      S_HI: begin
        if (div_end) begin
          div_d = 9'd0;
          sck_d = 1'b0;
          if (bit_q != 3'd7) begin
            state_d = S_LO;
            shift_d = {shift_q[6:0], 1'b0};
            do_d    = shift_q[6];
            bit_d   = bit_q + 3'd1;
          end else if (more_bytes) begin
            state_d = S_LO;
            shift_d = next_byte;
            do_d    = next_byte[7];
            bit_d   = 3'd0;
            byte_d  = byte_q + 9'd1;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end

      S_HOLD: begin
        if (div_end) begin
          state_d = S_DESEL;
          div_d   = 9'd0;
          ss_d    = 1'b1;
          do_d    = 1'b0;
        end else begin
          div_d = div_q + 9'd1;
        end
      end

      S_DESEL: begin
        if (div_q == DESEL_LAST) begin
          state_d = S_IDLE;
          div_d   = 9'd0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          div_d = div_q + 9'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = 9'd0;
        sck_d   = 1'b0;
        ss_d    = 1'b1;
        do_d    = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= 9'd0;
      bit_q     <= 3'd0;
      byte_q    <= 9'd0;
      shift_q   <= 8'd0;
      hold_q    <= 8'd0;
      cap_q     <= 1'b0;
      is_wr_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 8'd0;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      do_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      cap_q     <= cap_d;
      is_wr_q   <= is_wr_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      sck_q     <= sck_d;
      ss_q      <= ss_d;
      do_q      <= do_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign SPI_SCK   = sck_q;
  assign SPI_SS3   = ss_q;
  assign SPI_DO    = do_q;

endmodule

// File: tb/tb_osd_spi_tx.sv
// Bench for osd_spi_tx: two instances (CLK_DIV=4 and 2), a payload RAM per instance,
// and an SPI receiver model that decodes frames and timing from the pins.
module tb_osd_spi_tx;

  logic       clk, rst;
  logic       cv[2];
  logic [1:0] ct[2];
  logic [2:0] cl[2];
  logic       rdy[2], bsy[2], ren[2], sck[2], ss[2], sdo[2];
  logic [7:0] raddr[2], rdata[2];
  logic [7:0] ram[2][256];

  int vectors = 0;
  int miscompares = 0;

  osd_spi_tx #(.CLK_DIV(4)) dut0 (
    .clk_sys(clk), .reset(rst), .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_type(ct[0]), .cmd_line(cl[0]), .busy(bsy[0]), .rd_en(ren[0]),
    .rd_addr(raddr[0]), .rd_data(rdata[0]), .SPI_SCK(sck[0]), .SPI_SS3(ss[0]),
    .SPI_DO(sdo[0]));

  osd_spi_tx #(.CLK_DIV(2)) dut1 (
    .clk_sys(clk), .reset(rst), .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_type(ct[1]), .cmd_line(cl[1]), .busy(bsy[1]), .rd_en(ren[1]),
    .rd_addr(raddr[1]), .rd_data(rdata[1]), .SPI_SCK(sck[1]), .SPI_SS3(ss[1]),
    .SPI_DO(sdo[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (ren[d]) rdata[d] <= ram[d][raddr[d]];

  function automatic int dv(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic [7:0] exp_cmd(input logic [1:0] t, input logic [2:0] l);
    if (t == 2'd0) return 8'h40;
    if (t == 2'd1) return 8'h41;
    return 8'h20 | {5'd0, l};
  endfunction

  // Receiver / protocol monitor state
  int cyc = 0;
  int clr_req[2] = '{0, 0};
  int clr_seen[2] = '{-1, -1};
  int rises[2], frames[2], falls[2], ss_low[2], fall_cyc[2], rise_cyc[2];
  int first_rise[2], rise_last[2], spacing_viol[2], do_viol[2], do_chg[2];
  int ren_cnt[2], addr_viol[2], ren_timing_viol[2], partial_viol[2];
  int min_gap[2], rdy_rise_cyc[2], nb[2], rxn[2];
  logic       have_rise[2];
  logic [7:0] acc[2];
  logic [7:0] rxbuf[2][300];
  logic       prev_sck[2], prev_ss[2], prev_do[2], prev_rdy[2];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (clr_req[d] != clr_seen[d]) begin
        clr_seen[d] = clr_req[d];
        rises[d] = 0; frames[d] = 0; falls[d] = 0; ss_low[d] = 0; fall_cyc[d] = 0;
        rise_cyc[d] = -1; first_rise[d] = 0; rise_last[d] = 0; spacing_viol[d] = 0;
        do_viol[d] = 0; do_chg[d] = 0; ren_cnt[d] = 0; addr_viol[d] = 0;
        ren_timing_viol[d] = 0; partial_viol[d] = 0; min_gap[d] = 1000000;
        rdy_rise_cyc[d] = 0; nb[d] = 0; rxn[d] = 0; have_rise[d] = 1'b0; acc[d] = 8'd0;
      end
      if (sdo[d] !== prev_do[d]) begin
        do_chg[d] = cyc;
        if (sck[d] === 1'b1 && prev_sck[d] === 1'b1) do_viol[d]++;
      end
      if (ss[d] === 1'b0 && prev_ss[d] === 1'b1) begin
        falls[d]++; fall_cyc[d] = cyc; have_rise[d] = 1'b0; nb[d] = 0;
        if (rise_cyc[d] >= 0 && (cyc - rise_cyc[d]) < min_gap[d]) min_gap[d] = cyc - rise_cyc[d];
      end
      if (ss[d] === 1'b1 && prev_ss[d] === 1'b0) begin
        frames[d]++; ss_low[d] = cyc - fall_cyc[d]; rise_cyc[d] = cyc;
        if (nb[d] != 0) partial_viol[d]++;
      end
      if (sck[d] === 1'b1 && prev_sck[d] === 1'b0) begin
        rises[d]++;
        if (ss[d] === 1'b0) begin
          if (!have_rise[d]) first_rise[d] = cyc - fall_cyc[d];
          else if ((cyc - rise_last[d]) != 2 * dv(d)) spacing_viol[d]++;
          have_rise[d] = 1'b1; rise_last[d] = cyc;
          if ((cyc - do_chg[d]) < dv(d)) do_viol[d]++;
          acc[d] = {acc[d][6:0], sdo[d]};
          nb[d]++;
          if (nb[d] == 8) begin
            if (rxn[d] < 300) rxbuf[d][rxn[d]] = acc[d];
            rxn[d]++; nb[d] = 0;
          end
        end
      end
      if (ren[d] === 1'b1) begin
        if (raddr[d] !== 8'(ren_cnt[d])) addr_viol[d]++;
        if (!(sck[d] === 1'b1 && prev_sck[d] === 1'b0)) ren_timing_viol[d]++;
        ren_cnt[d]++;
      end
      if (rdy[d] === 1'b1 && prev_rdy[d] === 1'b0) rdy_rise_cyc[d] = cyc;
      prev_sck[d] = sck[d]; prev_ss[d] = ss[d]; prev_do[d] = sdo[d]; prev_rdy[d] = rdy[d];
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic mon_clear(input int d);
    clr_req[d]++;
    step();
  endtask

  // Presents a command and returns one negedge after it was accepted (cycle 1).
  task automatic issue(input int d, input logic [1:0] t, input logic [2:0] l);
    int k = 0;
    cv[d] = 1'b1; ct[d] = t; cl[d] = l;
    while (rdy[d] !== 1'b1 && k < 50000) begin step(); k++; end
    step();
    cv[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int k = 0;
    while (rdy[d] !== 1'b1 && k < budget) begin step(); k++; end
    if (k >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle[%0d]: still busy after %0d cycles, want idle", d, budget);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      vectors += 7;
      if (rdy[d] !== 1'b1)   begin miscompares++; $display("FAIL rst_ready[%0d]: got %b want 1", d, rdy[d]); end
      if (bsy[d] !== 1'b0)   begin miscompares++; $display("FAIL rst_busy[%0d]: got %b want 0", d, bsy[d]); end
      if (ren[d] !== 1'b0)   begin miscompares++; $display("FAIL rst_rd_en[%0d]: got %b want 0", d, ren[d]); end
      if (raddr[d] !== 8'd0) begin miscompares++; $display("FAIL rst_rd_addr[%0d]: got %h want 00", d, raddr[d]); end
      if (sck[d] !== 1'b0)   begin miscompares++; $display("FAIL rst_sck[%0d]: got %b want 0", d, sck[d]); end
      if (ss[d] !== 1'b1)    begin miscompares++; $display("FAIL rst_ss3[%0d]: got %b want 1", d, ss[d]); end
      if (sdo[d] !== 1'b0)   begin miscompares++; $display("FAIL rst_do[%0d]: got %b want 0", d, sdo[d]); end
    end
  endtask

  // Single enable frame on the CLK_DIV=4 instance.
  task automatic test_enable(input string tag);
    mon_clear(0);
    issue(0, 2'd1, 3'd0);
    vectors += 4;
    if (ss[0] !== 1'b0)  begin miscompares++; $display("FAIL %s_ss_c1: got %b want 0", tag, ss[0]); end
    if (sdo[0] !== 1'b0) begin miscompares++; $display("FAIL %s_do_c1: got %b want 0", tag, sdo[0]); end
    if (bsy[0] !== 1'b1) begin miscompares++; $display("FAIL %s_busy_c1: got %b want 1", tag, bsy[0]); end
    if (rdy[0] !== 1'b0) begin miscompares++; $display("FAIL %s_ready_c1: got %b want 0", tag, rdy[0]); end
    wait_idle(0, 1000);
    vectors += 9;
    if (rxn[0] != 1)           begin miscompares++; $display("FAIL %s_nbytes: got %0d want 1", tag, rxn[0]); end
    if (rxbuf[0][0] !== 8'h41) begin miscompares++; $display("FAIL %s_byte: got %h want 41", tag, rxbuf[0][0]); end
    if (rises[0] != 8)         begin miscompares++; $display("FAIL %s_rises: got %0d want 8", tag, rises[0]); end
    if (spacing_viol[0] != 0)  begin miscompares++; $display("FAIL %s_spacing: got %0d bad gaps want 0", tag, spacing_viol[0]); end
    if (first_rise[0] != 4)    begin miscompares++; $display("FAIL %s_first_rise: got %0d want 4", tag, first_rise[0]); end
    if (ss_low[0] != 68)       begin miscompares++; $display("FAIL %s_ss_low: got %0d want 68", tag, ss_low[0]); end
    if (rdy_rise_cyc[0] - rise_cyc[0] != 8) begin miscompares++;
      $display("FAIL %s_ready_delay: got %0d want 8", tag, rdy_rise_cyc[0] - rise_cyc[0]); end
    if (frames[0] != 1 || partial_viol[0] != 0) begin miscompares++;
      $display("FAIL %s_frames: got %0d frames %0d partial want 1/0", tag, frames[0], partial_viol[0]); end
    if (do_viol[0] != 0)       begin miscompares++; $display("FAIL %s_do_stable: got %0d violations want 0", tag, do_viol[0]); end
  endtask

  task automatic test_type3();
    mon_clear(0);
    cv[0] = 1'b1; ct[0] = 2'd3; cl[0] = 3'($urandom);
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || ss[0] !== 1'b1 || sck[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL type3_cycle%0d: got rdy=%b busy=%b ss=%b sck=%b want 1 0 1 0", i, rdy[0], bsy[0], ss[0], sck[0]);
      end
    end
    cv[0] = 1'b0;
    repeat (10) step();
    vectors++;
    if (falls[0] != 0 || rises[0] != 0 || ren_cnt[0] != 0) begin miscompares++;
      $display("FAIL type3_activity: got falls=%0d rises=%0d rd_en=%0d want 0", falls[0], rises[0], ren_cnt[0]); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    mon_clear(0);
    cv[0] = 1'b1; ct[0] = 2'd1; cl[0] = 3'd0;
    step();
    ct[0] = 2'd0;
    step();
    while (rdy[0] !== 1'b1 && k < 2000) begin step(); k++; end
    step();
    cv[0] = 1'b0;
    wait_idle(0, 2000);
    vectors += 6;
    if (frames[0] != 2 || falls[0] != 2) begin miscompares++;
      $display("FAIL b2b_frames: got %0d/%0d want 2/2", frames[0], falls[0]); end
    if (rxn[0] != 2) begin miscompares++; $display("FAIL b2b_nbytes: got %0d want 2", rxn[0]); end
    if (rxbuf[0][0] !== 8'h41 || rxbuf[0][1] !== 8'h40) begin miscompares++;
      $display("FAIL b2b_bytes: got %h %h want 41 40", rxbuf[0][0], rxbuf[0][1]); end
    if (min_gap[0] < 8) begin miscompares++; $display("FAIL b2b_gap: got %0d want >=8", min_gap[0]); end
    if (rises[0] != 16 || partial_viol[0] != 0) begin miscompares++;
      $display("FAIL b2b_rises: got %0d rises %0d partial want 16/0", rises[0], partial_viol[0]); end
    if (ss_low[0] != 68) begin miscompares++; $display("FAIL b2b_ss_low: got %0d want 68", ss_low[0]); end
  endtask

  task automatic test_write(input int d, input logic [2:0] line, input bit rand_data);
    logic [7:0] expv;
    int bad = 0;
    for (int a = 0; a < 256; a++) ram[d][a] = rand_data ? 8'($urandom) : (8'(a) ^ 8'h5A);
    mon_clear(d);
    issue(d, 2'd2, line);
    wait_idle(d, 20000);
    vectors++;
    if (rxn[d] != 257) begin miscompares++; $display("FAIL wr%0d_nbytes: got %0d want 257", d, rxn[d]); end
    for (int k = 0; k < 257 && k < rxn[d]; k++) begin
      expv = (k == 0) ? exp_cmd(2'd2, line) : ram[d][k-1];
      vectors++;
      if (rxbuf[d][k] !== expv) begin
        miscompares++; bad++;
        if (bad < 8) $display("FAIL wr%0d_byte%0d: got %h want %h", d, k, rxbuf[d][k], expv);
      end
    end
    vectors += 6;
    if (ren_cnt[d] != 256) begin miscompares++; $display("FAIL wr%0d_rd_en: got %0d pulses want 256", d, ren_cnt[d]); end
    if (addr_viol[d] != 0 || ren_timing_viol[d] != 0) begin miscompares++;
      $display("FAIL wr%0d_rd_order: got %0d addr %0d timing errors want 0", d, addr_viol[d], ren_timing_viol[d]); end
    if (rises[d] != 2056) begin miscompares++; $display("FAIL wr%0d_rises: got %0d want 2056", d, rises[d]); end
    if (ss_low[d] != 2056 * 2 * dv(d) + dv(d)) begin miscompares++;
      $display("FAIL wr%0d_ss_low: got %0d want %0d", d, ss_low[d], 2056 * 2 * dv(d) + dv(d)); end
    if (do_viol[d] != 0 || spacing_viol[d] != 0) begin miscompares++;
      $display("FAIL wr%0d_timing: got %0d do %0d spacing errors want 0", d, do_viol[d], spacing_viol[d]); end
    if (frames[d] != 1) begin miscompares++; $display("FAIL wr%0d_frames: got %0d want 1", d, frames[d]); end
  endtask

  task automatic test_reset_midframe();
    int k = 0;
    int rc;
    for (int a = 0; a < 256; a++) ram[0][a] = 8'($urandom);
    mon_clear(0);
    issue(0, 2'd2, 3'($urandom));
    while (rxn[0] < 101 && k < 10000) begin step(); k++; end
    if (k >= 10000) begin vectors++; miscompares++; $display("FAIL rstmid_reach: got %0d bytes want 101", rxn[0]); end
    repeat (20) step();
    #1 rst = 1'b1;
    #1;
    vectors += 2;
    if (ss[0] !== 1'b1 || sck[0] !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_async: got ss=%b sck=%b want 1 0", ss[0], sck[0]); end
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || ren[0] !== 1'b0 || raddr[0] !== 8'd0 || sdo[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got rdy=%b busy=%b rd_en=%b addr=%h do=%b want 1 0 0 00 0",
               rdy[0], bsy[0], ren[0], raddr[0], sdo[0]);
    end
    rc = ren_cnt[0];
    repeat (5) step();
    rst = 1'b0;
    repeat (40) step();
    vectors += 2;
    if (ren_cnt[0] != rc) begin miscompares++; $display("FAIL rstmid_rd_en: got %0d pulses want %0d", ren_cnt[0], rc); end
    if (rdy[0] !== 1'b1 || ss[0] !== 1'b1) begin miscompares++;
      $display("FAIL rstmid_release: got rdy=%b ss=%b want 1 1", rdy[0], ss[0]); end
    test_enable("post_rst");
  endtask

  // Random short commands on the CLK_DIV=2 instance against the command-byte model.
  task automatic test_random();
    logic [1:0] t;
    logic [2:0] l;
    for (int i = 0; i < 8; i++) begin
      t = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      l = 3'($urandom);
      mon_clear(1);
      issue(1, t, l);
      if (t == 2'd3) begin
        repeat (8) step();
        vectors++;
        if (falls[1] != 0 || bsy[1] !== 1'b0) begin miscompares++;
          $display("FAIL rnd%0d_drop: got falls=%0d busy=%b want 0 0", i, falls[1], bsy[1]); end
      end else begin
        wait_idle(1, 500);
        vectors += 3;
        if (rxn[1] != 1) begin miscompares++; $display("FAIL rnd%0d_nbytes: got %0d want 1", i, rxn[1]); end
        if (rxbuf[1][0] !== exp_cmd(t, l)) begin miscompares++;
          $display("FAIL rnd%0d_byte: got %h want %h", i, rxbuf[1][0], exp_cmd(t, l)); end
        if (ss_low[1] != 17 * dv(1)) begin miscompares++;
          $display("FAIL rnd%0d_ss_low: got %0d want %0d", i, ss_low[1], 17 * dv(1)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; ct[d] = 2'd0; cl[d] = 3'd0;
      for (int a = 0; a < 256; a++) ram[d][a] = 8'd0;
    end
    step(); step();
    test_reset();
    rst = 1'b0;
    step();
    test_enable("enable");
    test_type3();
    test_back_to_back();
    test_write(0, 3'd5, 1'b0);
    test_write(1, 3'($urandom), 1'b1);
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
